// File: rtl/operand_entry_sequencer.sv
// Operand entry sequencer: debounces two keys and walks X then Y entry.
// Presents both captured operands with VALID to the downstream adder.
module operand_entry_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] SW,
    input  logic [1:0] KEY,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic       VALID,
    output logic [2:0] STAGE
);

    typedef enum logic [1:0] {
        LOAD_X = 2'd0,
        LOAD_Y = 2'd1,
        SHOW   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [1:0]       stable_d;
    logic [1:0]       press;
    logic [CNT_W-1:0] cnt [2];

    state_t     state_q;
    state_t     state_d;
    logic [3:0] x_d;
    logic [3:0] y_d;
    logic       valid_d;
    logic [2:0] stage_d;

    // Two-flop synchroniser for the raw active-low keys
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    // Per-key debounce: accept a level only after it holds long enough
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stable <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == stable[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_MAX) begin
                    stable[k] <= sync2[k];
                    cnt[k]    <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    // One-cycle press pulse on each accepted falling edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stable_d <= 2'b11;
            press    <= 2'b00;
        end else begin
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end

    // Next state, operand capture and output decode; clear has priority
    always_comb begin
        state_d = state_q;
        x_d     = X;
        y_d     = Y;
        case (state_q)
            LOAD_X: begin
                if (press[0]) begin
                    state_d = LOAD_Y;
                    x_d     = SW;
                end
            end
            LOAD_Y: begin
                if (press[0]) begin
                    state_d = SHOW;
                    y_d     = SW;
                end
            end
            SHOW: begin
                if (press[0]) begin
                    state_d = LOAD_X;
                end
            end
            default: begin
                state_d = LOAD_X;
            end
        endcase
        if (press[1]) begin
            state_d = LOAD_X;
            x_d     = 4'h0;
            y_d     = 4'h0;
        end
        valid_d = (state_d == SHOW);
        case (state_d)
            LOAD_Y:  stage_d = 3'b010;
            SHOW:    stage_d = 3'b100;
            default: stage_d = 3'b001;
        endcase
    end

    // State, operand and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= LOAD_X;
            X       <= 4'h0;
            Y       <= 4'h0;
            VALID   <= 1'b0;
            STAGE   <= 3'b001;
        end else begin
            state_q <= state_d;
            X       <= x_d;
            Y       <= y_d;
            VALID   <= valid_d;
            STAGE   <= stage_d;
        end
    end

endmodule

// File: tb/tb_operand_entry_sequencer.sv
// Directed bench for operand_entry_sequencer with a 4-sample debounce.
// Expected values are hand-derived from the key timing of each step.
module tb_operand_entry_sequencer;

    logic       CLK;
    logic       RST;
    logic [3:0] SW;
    logic [1:0] KEY;
    logic [3:0] X;
    logic [3:0] Y;
    logic       VALID;
    logic [2:0] STAGE;

    int checks = 0;
    int errors = 0;

    operand_entry_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .SW(SW),
        .KEY(KEY),
        .X(X),
        .Y(Y),
        .VALID(VALID),
        .STAGE(STAGE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] ex,
                         input logic [3:0] ey, input logic ev,
                         input logic [2:0] es);
        logic [11:0] obs;
        logic [11:0] exp;
        obs = {X, Y, VALID, STAGE};
        exp = {ex, ey, ev, es};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed X=%h Y=%h V=%b S=%b expected X=%h Y=%h V=%b S=%b",
                   tag, X, Y, VALID, STAGE, ex, ey, ev, es);
        end
    endtask

    task automatic press(input logic [1:0] k, input int hold);
        KEY = k;
        tick(hold);
        KEY = 2'b11;
        tick(12);
    endtask

    initial begin
        RST = 1'b1;
        KEY = 2'b11;
        SW  = 4'h0;
        tick(2);
        check("reset", 4'h0, 4'h0, 1'b0, 3'b001);
        RST = 1'b0;

        // 1: idle keys
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("idle", 4'h0, 4'h0, 1'b0, 3'b001);
        end

        // 3: bounce never accepted
        SW  = 4'h5;
        KEY = 2'b10;
        tick(3);
        KEY = 2'b11;
        tick(1);
        KEY = 2'b10;
        tick(3);
        KEY = 2'b11;
        tick(12);
        check("bounce", 4'h0, 4'h0, 1'b0, 3'b001);

        // 2: enter X=9 with exact latency, then Y=7
        SW  = 4'h9;
        KEY = 2'b10;
        tick(7);
        check("x_e0p6", 4'h0, 4'h0, 1'b0, 3'b001);
        tick(1);
        check("x_e0p7", 4'h9, 4'h0, 1'b0, 3'b010);
        tick(12);
        KEY = 2'b11;
        tick(12);
        check("x_hold", 4'h9, 4'h0, 1'b0, 3'b010);
        SW  = 4'h7;
        KEY = 2'b10;
        tick(7);
        check("y_e0p6", 4'h9, 4'h0, 1'b0, 3'b010);
        tick(1);
        check("y_e0p7", 4'h9, 4'h7, 1'b1, 3'b100);
        KEY = 2'b11;
        tick(12);
        check("show", 4'h9, 4'h7, 1'b1, 3'b100);

        // 4: clear from SHOW
        KEY = 2'b01;
        tick(7);
        check("clr_e0p6", 4'h9, 4'h7, 1'b1, 3'b100);
        tick(1);
        check("clr_e0p7", 4'h0, 4'h0, 1'b0, 3'b001);
        KEY = 2'b11;
        tick(12);

        // SHOW -> LOAD_X keeps operands
        SW = 4'h2;
        press(2'b10, 10);
        SW = 4'h4;
        press(2'b10, 10);
        check("show2", 4'h2, 4'h4, 1'b1, 3'b100);
        SW = 4'hA;
        press(2'b10, 10);
        check("wrap", 4'h2, 4'h4, 1'b0, 3'b001);

        // 5: simultaneous enter and clear in LOAD_Y
        SW = 4'h3;
        press(2'b10, 10);
        check("ly", 4'h3, 4'h4, 1'b0, 3'b010);
        SW = 4'hF;
        press(2'b00, 10);
        check("both", 4'h0, 4'h0, 1'b0, 3'b001);

        // 6: reset mid-debounce with key held
        SW = 4'h3;
        press(2'b10, 10);
        check("pre_rst", 4'h3, 4'h0, 1'b0, 3'b010);
        SW  = 4'h6;
        KEY = 2'b10;
        tick(4);
        RST = 1'b1;
        #1;
        check("rst_async", 4'h0, 4'h0, 1'b0, 3'b001);
        tick(1);
        RST = 1'b0;
        tick(7);
        check("rst_e0p6", 4'h0, 4'h0, 1'b0, 3'b001);
        tick(1);
        check("rst_e0p7", 4'h6, 4'h0, 1'b0, 3'b010);
        KEY = 2'b11;
        tick(12);
        check("final", 4'h6, 4'h0, 1'b0, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
